// File: rtl/stream_demux_pkg.sv
// Shared constants for the four-way stream demultiplexer: channel count,
// select width and the channel index of each named output.
package stream_demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam logic [SEL_W-1:0] CH_A = 2'd0;
    localparam logic [SEL_W-1:0] CH_B = 2'd1;
    localparam logic [SEL_W-1:0] CH_C = 2'd2;
    localparam logic [SEL_W-1:0] CH_D = 2'd3;

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready holding register. A write always wins over a drain,
// so a slot that is read and written in the same cycle stays full with the
// new word, giving one word per cycle of throughput.
module demux_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Load on write, empty on drain; reset clears both flag and payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_wr_en) begin
            r_valid <= 1'b1;
            r_data  <= i_wr_data;
        end else if (r_valid && i_rd_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/stream_demux.sv
// Four-way stream demultiplexer. Each input word is steered by {s1,s0} into
// one of four independent one-entry slots; each slot drains on its own
// ready. The input is back-pressured only by the slot currently selected.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     s1,
    input  logic                     s0,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     busy
);

    logic [SEL_W-1:0]  w_sel;
    logic              w_accept;
    logic [NUM_CH-1:0] w_wr_en;

    assign w_sel    = {s1, s0};
    // The selected slot can take a word if it is empty or being drained now.
    assign in_ready = !out_valid[w_sel] || out_ready[w_sel];
    assign w_accept = in_valid && in_ready;
    assign busy     = |out_valid;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_slot
        assign w_wr_en[n] = w_accept && (w_sel == SEL_W'(n));

        demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .i_wr_en    (w_wr_en[n]),
            .i_wr_data  (in_data),
            .i_rd_ready (out_ready[n]),
            .o_valid    (out_valid[n]),
            .o_data     (out_data[n*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: each accepted word is queued on its
// channel, and a monitor pops and compares every word the DUT hands off.
module tb_stream_demux;
    import stream_demux_pkg::*;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          s1, s0;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [4*DW-1:0] out_data;
    logic          busy;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_q [4][$];

    stream_demux #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .s1        (s1),
        .s0        (s0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] ch_data(input int n);
        return out_data[n*DW +: DW];
    endfunction

    // Monitor: every handshake on an output channel pops that channel's queue.
    always @(negedge clk) begin
        if (!rst) begin
            for (int n = 0; n < 4; n++) begin
                if (out_valid[n] && out_ready[n]) begin
                    checks++;
                    if (exp_q[n].size() == 0) begin
                        errors++;
                        $display("FAIL drain_ch%0d: got %0h, expected no word", n, ch_data(n));
                    end else begin
                        logic [DW-1:0] e;
                        e = exp_q[n].pop_front();
                        if (ch_data(n) !== e) begin
                            errors++;
                            $display("FAIL drain_ch%0d: got %0h, expected %0h", n, ch_data(n), e);
                        end
                    end
                end
            end
        end
    end

    // Record the input handshake for this cycle, then advance to just past the edge.
    task automatic step();
        @(negedge clk);
        if (!rst && in_valid && in_ready)
            exp_q[{s1, s0}].push_back(in_data);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [DW-1:0] d);
        in_valid = v;
        {s1, s0} = sel;
        in_data  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        out_ready = 4'b0000;
        drive(1'b0, CH_A, 8'h00);
        #12;
        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        // No capture while reset is held
        drive(1'b1, CH_A, 8'h99);
        step();
        chk("rst_no_capture", 32'(out_valid), 32'h0);
        drive(1'b0, CH_A, 8'h00);
        rst = 1'b0;
        step();

        // Fill all four channels on consecutive cycles
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 8'((i + 1) * 8'h11));
            step();
        end
        chk("fill_out_valid", 32'(out_valid), 32'hF);
        chk("fill_busy", 32'(busy), 32'h1);
        chk("fill_a", 32'(ch_data(0)), 32'h11);
        chk("fill_b", 32'(ch_data(1)), 32'h22);
        chk("fill_c", 32'(ch_data(2)), 32'h33);
        chk("fill_d", 32'(ch_data(3)), 32'h44);
        drive(1'b1, CH_B, 8'h55);
        #1;
        chk("full_b_in_ready", 32'(in_ready), 32'h0);
        step();
        drive(1'b0, CH_A, 8'h00);
        chk("hold_b", 32'(ch_data(1)), 32'h22);
        out_ready = 4'b1111;
        step();
        out_ready = 4'b0000;
        chk("drain_all_valid", 32'(out_valid), 32'h0);

        // Simultaneous drain and refill on channel c
        drive(1'b1, CH_C, 8'hA5);
        step();
        drive(1'b0, CH_C, 8'h00);
        #1;
        chk("c_full_in_ready", 32'(in_ready), 32'h0);
        out_ready = 4'b0100;
        drive(1'b1, CH_C, 8'h5A);
        #1;
        chk("c_pass_in_ready", 32'(in_ready), 32'h1);
        step();
        drive(1'b0, CH_A, 8'h00);
        out_ready = 4'b0000;
        chk("c_refill_valid", 32'(out_valid), 32'h4);
        chk("c_refill_data", 32'(ch_data(2)), 32'h5A);
        out_ready = 4'b0100;
        step();
        out_ready = 4'b0000;
        chk("c_empty", 32'(out_valid), 32'h0);

        // Stream 16 words through channel d
        out_ready = 4'b1000;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, CH_D, 8'(i));
            #1;
            chk("d_stream_in_ready", 32'(in_ready), 32'h1);
            step();
            chk("d_stream_valid", 32'(out_valid), 32'h8);
            chk("d_stream_data", 32'(ch_data(3)), 32'(i));
        end
        drive(1'b0, CH_A, 8'h00);
        step();
        out_ready = 4'b0000;
        chk("d_stream_empty", 32'(out_valid), 32'h0);

        // Stall on full channel a, then switch select to c
        drive(1'b1, CH_A, 8'h3C);
        step();
        drive(1'b1, CH_A, 8'hC3);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("a_stall_in_ready", 32'(in_ready), 32'h0);
            step();
        end
        drive(1'b1, CH_C, 8'hC3);
        #1;
        chk("switch_in_ready", 32'(in_ready), 32'h1);
        step();
        drive(1'b0, CH_A, 8'h00);
        chk("switch_valid", 32'(out_valid), 32'h5);
        chk("switch_a_kept", 32'(ch_data(0)), 32'h3C);
        chk("switch_c_data", 32'(ch_data(2)), 32'hC3);

        // Fill everything, then reset between edges
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 8'(8'hE0 + i));
            step();
        end
        drive(1'b0, CH_A, 8'h00);
        chk("prefill_valid", 32'(out_valid), 32'hF);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        chk("async_rst_data", out_data, 32'h0);
        chk("async_rst_in_ready", 32'(in_ready), 32'h1);
        for (int n = 0; n < 4; n++) exp_q[n].delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, CH_D, 8'h77);
        step();
        drive(1'b0, CH_A, 8'h00);
        chk("post_rst_valid", 32'(out_valid), 32'h8);
        chk("post_rst_data", 32'(ch_data(3)), 32'h77);
        out_ready = 4'b1000;
        step();
        out_ready = 4'b0000;
        chk("post_rst_empty", 32'(out_valid), 32'h0);

        for (int n = 0; n < 4; n++)
            chk("queue_empty", 32'(exp_q[n].size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream offers a word.
REQ-005 SHALL have port in_ready  output  1  block accepts the offered word this cycle.
REQ-006 SHALL have port in_data  input  DATA_W  payload.
REQ-007 SHALL have port s1  input  1  channel select MSB, sampled with in_data.
REQ-008 SHALL have port s0  input  1  channel select LSB, sampled with in_data.
REQ-009 SHALL have port out_valid  output  4  per-channel word available; bit n = channel n.
REQ-010 SHALL have port out_ready  input  4  per-channel downstream accept; bit n = channel n.
REQ-011 SHALL have port out_data  output  4*DATA_W  channel n payload in bits [n*DATA_W +: DATA_W].
REQ-012 SHALL have port busy  output  1  OR of out_valid.

Function
REQ-013 SHALL decode channel sel = {s1,s0}: 00->a(0), 01->b(1), 10->c(2), 11->d(3).
REQ-014 SHALL hold one registered slot per channel (empty/full), four independent slots.
REQ-015 SHALL drive in_ready = !out_valid[sel] | out_ready[sel], combinationally from the current sel.
REQ-016 SHALL accept on in_valid & in_ready; on acceptance, write in_data to slot sel and set out_valid[sel] at the next edge (latency 1 cycle).
REQ-017 SHALL treat out_valid[n] & out_ready[n] as a drain of slot n; clear out_valid[n] next edge unless refilled the same cycle.
REQ-018 SHALL on simultaneous drain and accept for the same channel keep out_valid[n]=1 and load the new word (full throughput, one word/cycle/channel).
REQ-019 SHALL leave slots other than sel unaffected by an input transfer; drains on other channels proceed in the same cycle.
REQ-020 SHALL hold out_data[n] stable while out_valid[n]=1 and out_ready[n]=0.
REQ-021 SHALL not require in_valid to stay asserted, nor in_data/sel to stay stable, while in_ready=0; no word is captured unless the handshake completes.
REQ-022 SHALL make out_ready[n] with out_valid[n]=0 a no-op.
REQ-023 SHALL never drop or duplicate a word; per-channel order equals input order.

Reset
REQ-024 SHALL on rst=1, immediately and regardless of clk, clear out_valid to 4'b0000, out_data to all zeros, busy to 0.
REQ-025 SHALL during reset keep slots empty, making in_ready = 1; no transfer is captured while rst=1.
REQ-026 SHALL on reset mid-operation discard all buffered words; first edge after release operates normally.

Structure
REQ-027 SHALL place the channel count (4), select width (2) and the channel index constants CH_A..CH_D (0..3) in a shared package stream_demux_pkg; DATA_W stays a module parameter.
REQ-028 SHALL implement each slot as sub-module demux_slot (valid/ready one-entry register, DATA_W parameter), instantiated four times.
REQ-029 SHALL contain no other state than the four slots.

Verification
REQ-030 SHALL cover: reset with all out_ready=0 -> out_valid=0000, out_data=0, in_ready=1, busy=0.
REQ-031 SHALL cover: send 0x11,0x22,0x33,0x44 with sel 00,01,10,11 on consecutive cycles, out_ready=0000 -> out_valid=1111 after 4th edge, each channel holding its word; 5th word 0x55 sel=01 sees in_ready=0.
REQ-032 SHALL cover: channel c full with 0xA5, out_ready[2]=1 and in_valid=1 sel=10 data 0x5A in the same cycle -> in_ready=1, next cycle out_valid[2]=1, out_data[2]=0x5A, 0xA5 delivered exactly once.
REQ-033 SHALL cover: streaming 16 words 0x00..0x0F to channel d with out_ready[3]=1 continuously -> one word per cycle, in order, latency 1, in_ready never 0.
REQ-034 SHALL cover: channel a full, in_valid=1 sel=00 stalled 3 cycles then sel changed to 10 -> word accepted into channel c on the switch cycle, channel a unchanged.
REQ-035 SHALL cover: rst asserted between edges with all four slots full -> out_valid=0000 before next clk edge, busy=0, subsequent 0x77 to sel=11 appears on out_data[3] one cycle after acceptance.
